// File: rtl/threshold_compress_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : threshold_compress_sched_if
//  Description : Bundles the job control, preactivation stream, packed word
//                stream and compressor side-band of threshold_compress_sched.
//                "slave" is the sequencer's view; "master" is the view of the
//                surrounding core plus compressor.
//  Revision    : 1.0  initial release
// ============================================================================
interface threshold_compress_sched_if #(
    parameter int OUTPUT_WIDTH = 8,
    parameter int CNT_WIDTH    = 16
);
    // job control
    logic                    start;
    logic [CNT_WIDTH-1:0]    n_groups;
    logic [31:0]             threshold;
    logic                    busy;
    logic                    done;
    // preactivation stream
    logic                    preact_valid;
    logic [31:0]             preact;
    logic                    preact_ready;
    // packed word stream
    logic                    word_valid;
    logic [31:0]             word;
    logic                    word_last;
    logic                    word_ready;
    // compressor side
    logic [31:0]             cmp_data;
    logic [31:0]             cmp_threshold;
    logic                    cmp_enable;
    logic                    cmp_rst_n;
    logic [OUTPUT_WIDTH-1:0] cmp_byte;
    logic                    cmp_ready;

    modport slave (
        input  start, n_groups, threshold,
        input  preact_valid, preact,
        input  word_ready,
        input  cmp_byte, cmp_ready,
        output busy, done,
        output preact_ready,
        output word_valid, word, word_last,
        output cmp_data, cmp_threshold, cmp_enable, cmp_rst_n
    );

    modport master (
        output start, n_groups, threshold,
        output preact_valid, preact,
        output word_ready,
        output cmp_byte, cmp_ready,
        input  busy, done,
        input  preact_ready,
        input  word_valid, word, word_last,
        input  cmp_data, cmp_threshold, cmp_enable, cmp_rst_n
    );
endinterface
`default_nettype wire

// File: rtl/threshold_compress_sched.sv
`default_nettype none
// ============================================================================
//  Module      : threshold_compress_sched
//  Description : Job sequencer for one threshold_compress instance. Latches a
//                threshold pair and a group count, feeds TRITS preactivations
//                per group into the compressor, collects one byte per group
//                and packs the bytes little-endian into 32-bit words.
//  Revision    : 1.0  initial release
// ============================================================================
module threshold_compress_sched #(
    parameter int OUTPUT_WIDTH = 8,
    parameter int TRITS        = 5,
    parameter int CNT_WIDTH    = 16
) (
    input  wire                        clk_i,
    input  wire                        rst_ni,
    threshold_compress_sched_if.slave  bus
);

    localparam int BYTES_PER_WORD = 32 / OUTPUT_WIDTH;
    localparam int LANE_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int TRIT_W         = $clog2(TRITS + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [31:0]           threshold_q;
    logic [CNT_WIDTH-1:0]  n_groups_q;
    logic [CNT_WIDTH-1:0]  groups_done;
    logic [TRIT_W-1:0]     trit_cnt;
    logic [LANE_W-1:0]     byte_idx;
    logic [31:0]           word_q;
    logic                  last_q;
    logic                  zero_done;

    logic                  start_job;
    logic                  start_empty;
    logic                  feed_hs;
    logic                  last_trit;
    logic                  capture;
    logic                  lane_full;
    logic                  final_group;
    logic [CNT_WIDTH:0]    groups_after;

    // One extra bit so the final-group compare never wraps at the maximum count.
    assign groups_after = {1'b0, groups_done} + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign final_group  = (groups_after == {1'b0, n_groups_q});

    assign start_job    = (state == S_IDLE) && bus.start && (bus.n_groups != '0);
    assign start_empty  = (state == S_IDLE) && bus.start && (bus.n_groups == '0);
    assign feed_hs      = (state == S_FEED) && bus.preact_valid;
    assign last_trit    = (trit_cnt == TRIT_W'(TRITS - 1));
    assign capture      = (state == S_WAIT) && bus.cmp_ready;
    assign lane_full    = (byte_idx == LANE_W'(BYTES_PER_WORD - 1));

    // Preactivations pass straight through; the threshold is the job-latched copy.
    assign bus.cmp_data      = bus.preact;
    assign bus.cmp_threshold = threshold_q;
    assign bus.word          = word_q;

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_next       = state;
        bus.busy         = 1'b0;
        bus.done         = zero_done;
        bus.preact_ready = 1'b0;
        bus.cmp_enable   = 1'b0;
        bus.word_valid   = 1'b0;
        bus.word_last    = 1'b0;
        bus.cmp_rst_n    = rst_ni;

        case (state)
            S_IDLE: begin
                if (start_job) begin
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                bus.busy      = 1'b1;
                bus.cmp_rst_n = 1'b0;
                state_next    = S_FEED;
            end
            S_FEED: begin
                bus.busy         = 1'b1;
                bus.preact_ready = 1'b1;
                bus.cmp_enable   = feed_hs;
                if (feed_hs && last_trit) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                bus.busy = 1'b1;
                if (capture) begin
                    state_next = (lane_full || final_group) ? S_OUT : S_FEED;
                end
            end
            S_OUT: begin
                bus.busy       = 1'b1;
                bus.word_valid = 1'b1;
                bus.word_last  = last_q;
                if (bus.word_ready) begin
                    state_next = last_q ? S_DONE : S_FEED;
                end
            end
            S_DONE: begin
                bus.busy   = 1'b1;
                bus.done   = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Job datapath: latched parameters, trit/group counters and word packing.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            threshold_q <= '0;
            n_groups_q  <= '0;
            groups_done <= '0;
            trit_cnt    <= '0;
            byte_idx    <= '0;
            word_q      <= '0;
            last_q      <= 1'b0;
            zero_done   <= 1'b0;
        end else begin
            // An empty job completes immediately with a single done pulse.
            zero_done <= start_empty;

            case (state)
                S_IDLE: begin
                    if (start_job) begin
                        threshold_q <= bus.threshold;
                        n_groups_q  <= bus.n_groups;
                    end
                end
                S_CLEAR: begin
                    groups_done <= '0;
                    trit_cnt    <= '0;
                    byte_idx    <= '0;
                    word_q      <= '0;
                    last_q      <= 1'b0;
                end
                S_FEED: begin
                    if (feed_hs) begin
                        trit_cnt <= last_trit ? '0 : trit_cnt + TRIT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (capture) begin
                        for (int k = 0; k < BYTES_PER_WORD; k++) begin
                            if (byte_idx == LANE_W'(k)) begin
                                word_q[k*OUTPUT_WIDTH +: OUTPUT_WIDTH] <= bus.cmp_byte;
                            end
                        end
                        byte_idx    <= byte_idx + LANE_W'(1);
                        groups_done <= groups_done + CNT_WIDTH'(1);
                        last_q      <= final_group;
                    end
                end
                S_OUT: begin
                    // Accepted word leaves; the next word starts from an all-zero image.
                    if (bus.word_ready) begin
                        word_q   <= '0;
                        byte_idx <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
